// File: rtl/axi4_arb_pkg.sv
// Shared types and constants for the AXI4 crossbar arbiters.
package axi4_arb_pkg;

    localparam int unsigned BEAT_CNT_W = 8;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ADDR,
        ARB_DATA,
        ARB_RESP
    } arb_state_e;

endpackage

// File: rtl/axi4_wr_arbiter_if.sv
// Write-arbiter bus bundle: requests and slave-side handshakes in, grant state out.
interface axi4_wr_arbiter_if #(
    parameter int unsigned MASTER_NUM = 4,
    parameter int unsigned ID_W       = $clog2(MASTER_NUM)
);
    import axi4_arb_pkg::*;

    logic [MASTER_NUM-1:0] aw_req;
    logic                  s_awvalid;
    logic                  s_awready;
    logic                  s_wvalid;
    logic                  s_wready;
    logic                  s_wlast;
    logic                  s_bvalid;
    logic                  s_bready;
    logic [MASTER_NUM-1:0] grant;
    logic [ID_W-1:0]       grant_id;
    logic                  grant_valid;
    logic                  w_en;
    logic [BEAT_CNT_W-1:0] beat_cnt;

    // Arbiter side.
    modport slave (
        input  aw_req, s_awvalid, s_awready, s_wvalid, s_wready, s_wlast, s_bvalid, s_bready,
        output grant, grant_id, grant_valid, w_en, beat_cnt
    );

    // Crossbar side.
    modport master (
        output aw_req, s_awvalid, s_awready, s_wvalid, s_wready, s_wlast, s_bvalid, s_bready,
        input  grant, grant_id, grant_valid, w_en, beat_cnt
    );

endinterface

// File: rtl/axi4_rr_picker.sv
// Combinational round-robin picker: first requester after last_id, wrapping.
module axi4_rr_picker #(
    parameter int unsigned MASTER_NUM = 4,
    parameter int unsigned ID_W       = $clog2(MASTER_NUM)
) (
    input  logic [MASTER_NUM-1:0] req,
    input  logic [ID_W-1:0]       last_id,
    output logic [MASTER_NUM-1:0] gnt_onehot,
    output logic [ID_W-1:0]       gnt_id,
    output logic                  gnt_any
);

    always_comb begin
        gnt_onehot = '0;
        gnt_id     = '0;
        gnt_any    = 1'b0;
        // Offsets 1..MASTER_NUM so last_id itself is scanned last.
        for (int unsigned k = 1; k <= MASTER_NUM; k++) begin
            logic [ID_W-1:0] idx;
            idx = ID_W'((32'(last_id) + k) % MASTER_NUM);
            if (!gnt_any && req[idx]) begin
                gnt_any         = 1'b1;
                gnt_onehot[idx] = 1'b1;
                gnt_id          = idx;
            end
        end
    end

endmodule

// File: rtl/axi4_wr_arbiter.sv
// Per-slave AXI4 write-path arbiter; holds a round-robin grant for a whole write burst.
// Define AXI4_ARB_BLOCK_B_EN to also hold the grant through the B handshake.
module axi4_wr_arbiter
    import axi4_arb_pkg::*;
#(
    parameter int unsigned MASTER_NUM = 4,
    parameter int unsigned ID_W       = $clog2(MASTER_NUM)
) (
    input  logic               clk,
    input  logic               rstn,
    axi4_wr_arbiter_if.slave   bus
);

    arb_state_e            state_q, state_d;
    logic [MASTER_NUM-1:0] grant_q, grant_d;
    logic [ID_W-1:0]       grant_id_q, grant_id_d;
    logic                  grant_valid_q, grant_valid_d;
    logic [BEAT_CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [ID_W-1:0]       last_id_q, last_id_d;

    logic [MASTER_NUM-1:0] pick_onehot;
    logic [ID_W-1:0]       pick_id;
    logic                  pick_any;
    logic                  aw_hs, w_hs, release_grant;

    axi4_rr_picker #(
        .MASTER_NUM (MASTER_NUM),
        .ID_W       (ID_W)
    ) u_picker (
        .req        (bus.aw_req),
        .last_id    (last_id_q),
        .gnt_onehot (pick_onehot),
        .gnt_id     (pick_id),
        .gnt_any    (pick_any)
    );

    assign aw_hs = bus.s_awvalid & bus.s_awready;
    assign w_hs  = bus.s_wvalid & bus.s_wready;

`ifdef AXI4_ARB_BLOCK_B_EN
    logic b_hs;
    assign b_hs = bus.s_bvalid & bus.s_bready;
`else
    logic unused_b;
    assign unused_b = bus.s_bvalid ^ bus.s_bready;
`endif

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        grant_id_d    = grant_id_q;
        grant_valid_d = grant_valid_q;
        beat_cnt_d    = beat_cnt_q;
        last_id_d     = last_id_q;
        release_grant = 1'b0;

        unique case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    grant_d       = pick_onehot;
                    grant_id_d    = pick_id;
                    grant_valid_d = 1'b1;
                    last_id_d     = pick_id;
                    beat_cnt_d    = '0;
                    state_d       = ARB_ADDR;
                end
            end
            ARB_ADDR: begin
                if (aw_hs) state_d = ARB_DATA;
            end
            ARB_DATA: begin
                if (w_hs) begin
                    if (beat_cnt_q != '1) beat_cnt_d = beat_cnt_q + BEAT_CNT_W'(1);
                    if (bus.s_wlast) begin
`ifdef AXI4_ARB_BLOCK_B_EN
                        state_d = ARB_RESP;
`else
                        release_grant = 1'b1;
`endif
                    end
                end
            end
`ifdef AXI4_ARB_BLOCK_B_EN
            ARB_RESP: begin
                if (b_hs) release_grant = 1'b1;
            end
`endif
            default: release_grant = 1'b1;
        endcase

        // grant_id is kept after release; only grant/grant_valid clear.
        if (release_grant) begin
            state_d       = ARB_IDLE;
            grant_d       = '0;
            grant_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= ARB_IDLE;
            grant_q       <= '0;
            grant_id_q    <= '0;
            grant_valid_q <= 1'b0;
            beat_cnt_q    <= '0;
            last_id_q     <= ID_W'(MASTER_NUM - 1);
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            grant_id_q    <= grant_id_d;
            grant_valid_q <= grant_valid_d;
            beat_cnt_q    <= beat_cnt_d;
            last_id_q     <= last_id_d;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.grant_id    = grant_id_q;
    assign bus.grant_valid = grant_valid_q;
    assign bus.w_en        = (state_q == ARB_DATA);
    assign bus.beat_cnt    = beat_cnt_q;

endmodule

// File: tb/tb_axi4_wr_arbiter.sv
// Scoreboard bench for axi4_wr_arbiter: grants and final beat counts checked by a monitor.
module tb_axi4_wr_arbiter;

    localparam int unsigned MN = 4;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    axi4_wr_arbiter_if #(.MASTER_NUM(MN)) bus ();

    axi4_wr_arbiter #(.MASTER_NUM(MN)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0] exp_grant_q[$];
    int         exp_id_q[$];
    int         exp_beats_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic expect_grant(input logic [3:0] g, input int id);
        exp_grant_q.push_back(g);
        exp_id_q.push_back(id);
    endtask

    // Monitor: pop grant expectations on grant_valid rise, beat counts on its fall.
    logic prev_gv = 1'b0;
    always @(negedge clk) begin
        if (!rstn) begin
            prev_gv = 1'b0;
        end else begin
            if (bus.grant_valid && !prev_gv) begin
                if (exp_grant_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_grant: got grant %b expected none", bus.grant);
                end else begin
                    chk("grant", 32'(bus.grant), 32'(exp_grant_q.pop_front()));
                    chk("grant_id", 32'(bus.grant_id), 32'(exp_id_q.pop_front()));
                end
            end
            if (!bus.grant_valid && prev_gv) begin
                if (exp_beats_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_release: got beat_cnt %0d expected none",
                             bus.beat_cnt);
                end else begin
                    chk("final_beat_cnt", 32'(bus.beat_cnt), 32'(exp_beats_q.pop_front()));
                end
            end
            prev_gv = bus.grant_valid;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        bus.s_awvalid = 1'b0;
        bus.s_awready = 1'b0;
        bus.s_wvalid  = 1'b0;
        bus.s_wready  = 1'b0;
        bus.s_wlast   = 1'b0;
        bus.s_bvalid  = 1'b0;
        bus.s_bready  = 1'b0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        idle_bus();
        bus.aw_req = '0;
        cyc();
        cyc();
        rstn = 1'b1;
    endtask

    task automatic wait_gv();
        int k = 0;
        while (!bus.grant_valid && k < 20) begin
            cyc();
            k++;
        end
        chk("grant_wait", 32'(bus.grant_valid), 32'd1);
    endtask

    // One full write transaction once the grant appears; new_req replaces aw_req after grant.
    task automatic run_txn(input int n, input bit aw_with_w, input int stall_beat,
                           input logic [3:0] new_req, input logic [3:0] exp_g);
        wait_gv();
        chk("w_en_addr", 32'(bus.w_en), 32'd0);
        bus.aw_req    = new_req;
        bus.s_awvalid = 1'b1;
        bus.s_awready = 1'b1;
        bus.s_wvalid  = aw_with_w;
        bus.s_wready  = aw_with_w;
        bus.s_wlast   = 1'b0;
        cyc();
        bus.s_awvalid = 1'b0;
        bus.s_awready = 1'b0;
        chk("w_en_data", 32'(bus.w_en), 32'd1);
        chk("beat_after_aw", 32'(bus.beat_cnt), 32'd0);
        chk("grant_hold", 32'(bus.grant), 32'(exp_g));
        for (int b = 1; b <= n; b++) begin
            if (b == stall_beat) begin
                for (int s = 0; s < 3; s++) begin
                    bus.s_wvalid = 1'b1;
                    bus.s_wready = 1'b0;
                    bus.s_wlast  = (b == n);
                    bus.aw_req   = ~bus.aw_req;
                    cyc();
                    chk("beat_stall", 32'(bus.beat_cnt), 32'(b - 1));
                    chk("grant_stall", 32'(bus.grant), 32'(exp_g));
                end
                bus.aw_req = new_req;
            end
            bus.s_wvalid = 1'b1;
            bus.s_wready = 1'b1;
            bus.s_wlast  = (b == n);
            if (b == n) exp_beats_q.push_back(n);
            cyc();
            chk("beat_cnt", 32'(bus.beat_cnt), 32'(b));
        end
        bus.s_wvalid = 1'b0;
        bus.s_wready = 1'b0;
        bus.s_wlast  = 1'b0;
`ifdef AXI4_ARB_BLOCK_B_EN
        chk("gv_resp", 32'(bus.grant_valid), 32'd1);
        chk("w_en_resp", 32'(bus.w_en), 32'd0);
        bus.s_bvalid = 1'b1;
        bus.s_bready = 1'b0;
        cyc();
        chk("gv_b_wait", 32'(bus.grant_valid), 32'd1);
        bus.s_bready = 1'b1;
        cyc();
        bus.s_bvalid = 1'b0;
        bus.s_bready = 1'b0;
`endif
        chk("gv_release", 32'(bus.grant_valid), 32'd0);
        chk("grant_release", 32'(bus.grant), 32'd0);
        chk("w_en_release", 32'(bus.w_en), 32'd0);
    endtask

    logic [3:0] rr_order [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    initial begin
        idle_bus();
        bus.aw_req = '0;
        cyc();
        cyc();
        chk("rst_grant", 32'(bus.grant), 32'd0);
        chk("rst_grant_id", 32'(bus.grant_id), 32'd0);
        chk("rst_gv", 32'(bus.grant_valid), 32'd0);
        chk("rst_w_en", 32'(bus.w_en), 32'd0);
        chk("rst_beat_cnt", 32'(bus.beat_cnt), 32'd0);
        rstn = 1'b1;
        cyc();

        // 0110 from reset: master 1 first, then master 2 after one idle cycle.
        expect_grant(4'b0010, 1);
        expect_grant(4'b0100, 2);
        bus.aw_req = 4'b0110;
        run_txn(4, 1'b0, 0, 4'b0110, 4'b0010);
        cyc();
        chk("bubble_grant", 32'(bus.grant_valid), 32'd1);
        run_txn(4, 1'b0, 0, 4'b0000, 4'b0100);
        cyc();

        // All request, from reset: 0,1,2,3,0.
        do_reset();
        for (int i = 0; i < 5; i++) expect_grant(rr_order[i], i % 4);
        bus.aw_req = 4'b1111;
        for (int i = 0; i < 4; i++) run_txn(2, 1'b0, 0, 4'b1111, rr_order[i]);
        run_txn(2, 1'b0, 0, 4'b0000, rr_order[4]);
        cyc();

        // Stalled 16-beat burst with aw_req toggling; last_id=0 so master 2.
        expect_grant(4'b0100, 2);
        bus.aw_req = 4'b0100;
        run_txn(16, 1'b0, 5, 4'b0000, 4'b0100);
        cyc();

        // W valid during AW cycle not counted; last_id=2 so scan 3,0 -> master 0.
        expect_grant(4'b0001, 0);
        bus.aw_req = 4'b0001;
        run_txn(1, 1'b1, 0, 4'b0000, 4'b0001);
        cyc();

        // Reset at beat 2 of 8; afterwards master 3 wins from reset priority.
        expect_grant(4'b0010, 1);
        bus.aw_req = 4'b0010;
        wait_gv();
        bus.aw_req    = 4'b0000;
        bus.s_awvalid = 1'b1;
        bus.s_awready = 1'b1;
        cyc();
        bus.s_awvalid = 1'b0;
        bus.s_awready = 1'b0;
        for (int b = 1; b <= 2; b++) begin
            bus.s_wvalid = 1'b1;
            bus.s_wready = 1'b1;
            bus.s_wlast  = 1'b0;
            cyc();
            chk("abort_beat_cnt", 32'(bus.beat_cnt), 32'(b));
        end
        rstn = 1'b0;
        #1;
        chk("abort_grant", 32'(bus.grant), 32'd0);
        chk("abort_grant_id", 32'(bus.grant_id), 32'd0);
        chk("abort_gv", 32'(bus.grant_valid), 32'd0);
        chk("abort_w_en", 32'(bus.w_en), 32'd0);
        chk("abort_beat_cnt0", 32'(bus.beat_cnt), 32'd0);
        idle_bus();
        cyc();
        cyc();
        rstn = 1'b1;
        expect_grant(4'b1000, 3);
        bus.aw_req = 4'b1000;
        run_txn(3, 1'b0, 0, 4'b0000, 4'b1000);

        repeat (4) cyc();
        chk("grant_queue_empty", 32'(exp_grant_q.size()), 32'd0);
        chk("beats_queue_empty", 32'(exp_beats_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/axi4_wr_arbiter.md
# axi4_wr_arbiter

Per-slave write-path arbiter for the AXI4 crossbar. Selects one of `MASTER_NUM` masters whose AW request targets this slave, using round-robin, and holds that grant for the whole write transaction so the crossbar's AW/W (and optionally B) muxes stay locked to one master. The crossbar instantiates one per slave port and drives its muxes from `grant`/`grant_id`.

## Interface
- `MASTER_NUM`, 4, number of requesting masters (matches `MASTER_NUM` in config.sv); ≥2.
- `ID_W`, `$clog2(MASTER_NUM)`, width of `grant_id`.
- `clk` in 1: single clock, rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `aw_req` in MASTER_NUM: bit i = master i AWVALID, decoded to this slave.
- `s_awvalid`, `s_awready` in 1: muxed AW handshake on the slave side.
- `s_wvalid`, `s_wready`, `s_wlast` in 1: muxed W handshake on the slave side.
- `s_bvalid`, `s_bready` in 1: B handshake on the slave side.
- `grant` out MASTER_NUM: one-hot grant, zero when idle.
- `grant_id` out ID_W: index of granted master.
- `grant_valid` out 1: a grant is held.
- `w_en` out 1: W channel routing enabled. The crossbar gates WVALID/WREADY with it.
- `beat_cnt` out 8: W beats accepted in the current transaction. Saturates at 255.

## Operation
- States: IDLE, ADDR, DATA, RESP (RESP exists only with the macro).
- IDLE:
  - If `aw_req` != 0, pick the first requester scanning from `last_id+1` upward, wrapping modulo MASTER_NUM.
  - Register `grant`, `grant_id` and `grant_valid=1`, set `last_id` to the winner, clear `beat_cnt`, and go to ADDR.
- ADDR: hold grant; `w_en=0`. On `s_awvalid & s_awready`, go to DATA.
- DATA: `w_en=1`.
  - Each `s_wvalid & s_wready` increments `beat_cnt`.
  - A beat with `s_wlast` ends the state: go to RESP with the macro, otherwise release.
- RESP: `w_en=0`. On `s_bvalid & s_bready`, release.
- Release: next cycle the block is in IDLE with `grant=0`, `grant_valid=0`, `w_en=0`; `beat_cnt` keeps its final value until the next grant.
- `aw_req` changes while a grant is held are ignored. A requester dropping AWVALID is an AXI violation; the grant is still held.
- Single requester: wins every time. Requests arriving during a held grant wait.
- Reset (any time, including mid-burst): state IDLE, `grant=0`, `grant_id=0`, `grant_valid=0`, `w_en=0`, `beat_cnt=0`, `last_id=MASTER_NUM-1` (so master 0 has first priority).

## Timing
- `aw_req` seen in IDLE at edge t → `grant`/`grant_valid` high after edge t (visible in cycle t+1). Outputs are registered, with no combinational path from inputs to outputs.
- AW handshake in cycle c → `w_en=1` from cycle c+1. W beats are never accepted in the same cycle as AW.
- Last W beat (no macro) or B handshake (macro) in cycle c → `grant_valid=0` in cycle c+1. The earliest next grant is cycle c+2, so there is exactly one idle bubble between transactions.
- `beat_cnt` updates the cycle after each accepted beat.

## Configuration
- `AXI4_ARB_BLOCK_B_EN` defined:
  - DATA → RESP on the last W beat.
  - Grant is held until the B handshake, so the crossbar routes B by `grant_id` with no ID lookup.
- Not defined:
  - Release on the WLAST beat; RESP is unreachable.
  - The crossbar must route B by AXI ID.

## Structure
- Package `axi4_arb_pkg`: state enum `arb_state_e {ARB_IDLE, ARB_ADDR, ARB_DATA, ARB_RESP}` and the `BEAT_CNT_W=8` constant.
- Sub-module `axi4_rr_picker`: purely combinational. Takes `req`, `last_id` and returns one-hot plus index. It is reused for the read-path arbiter.

## Test plan
- Reset then `aw_req=4'b0110` → cycle t+1: `grant=4'b0010`, `grant_id=1`. After AW, 4 W beats with WLAST on beat 4, and (macro) a B handshake → release. The next grant is `4'b0100` after a one-cycle gap.
- `aw_req=4'b1111` held across 5 transactions → grant order 0,1,2,3,0.
- During DATA, `aw_req` toggles and W stalls (`s_wready=0` for 3 cycles) → grant unchanged, `beat_cnt` steps only on accepted beats, final value = burst length (e.g. 16).
- W valid asserted in the AW handshake cycle → no beat counted; `w_en` rises next cycle.
- `rstn` low mid-DATA at beat 2 of 8 → all outputs 0 immediately. After release, `aw_req=4'b1000` → grant master 3 (priority reset to 0-first, scan 0..3).
- With and without `AXI4_ARB_BLOCK_B_EN`: WLAST beat at cycle c → `grant_valid` falls at c+1 (undefined) or stays high until one cycle after the B handshake (defined).
